// File: rtl/siren_pkg.sv
// Shared types and default constants for the siren alarm controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package siren_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        LOCKED = 2'd2
    } code_state_t;

    typedef logic [1:0] key_idx_t;

    // Default code: digits 2,0,3,1 with digit i at bits [2i+1:2i].
    localparam int         DEF_CODE_LEN      = 4;
    localparam logic [7:0] DEF_CODE          = 8'b01_11_00_10;
    localparam int         DEF_TIMEOUT_TICKS = 50;
    localparam int         DEF_LOCK_ERRS     = 3;
    localparam int         DEF_LOCK_TICKS    = 100;

    // Larger of two integers, used to size the shared tick counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_press_detector.sv
// Turns synchronized keypad levels into single-cycle press events with key index.
// Latency: press is combinational from keypad against the registered key_held.
// Backpressure: none; the keypad is sampled every cycle.
import siren_pkg::*;

module key_press_detector (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad,
    output logic       press,
    output logic       press_valid,
    output key_idx_t   key_idx
);

    logic key_held;
    logic any_key;

    assign any_key = |keypad;

    // Remember whether any key was down last cycle; reset forces "held" so a
    // key kept down through reset release must be let go before it counts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_held <= 1'b1;
        end else begin
            key_held <= any_key;
        end
    end

    assign press       = !key_held && any_key;
    assign press_valid = $onehot(keypad);

    // Encode the set bit's position; only meaningful when press_valid is high.
    always_comb begin
        key_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (keypad[i]) begin
                key_idx = key_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_code_entry.sv
// Matches keypad press sequences against a fixed code; pulses code_ok/code_err, enforces timeout and lockout.
// Latency: state/digit_cnt update on the press edge; code_ok/code_err are high for the following cycle.
// Backpressure: none; pulses are fire-and-forget and presses during lockout are dropped.
import siren_pkg::*;

module keypad_code_entry #(
    parameter int                    CODE_LEN      = DEF_CODE_LEN,
    parameter logic [2*CODE_LEN-1:0] CODE          = DEF_CODE,
    parameter int                    TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int                    LOCK_ERRS     = DEF_LOCK_ERRS,
    parameter int                    LOCK_TICKS    = DEF_LOCK_TICKS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ENA,
    input  logic [3:0]                      keypad,
    output logic                            code_ok,
    output logic                            code_err,
    output logic                            entry_active,
    output logic                            locked,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int TW = $clog2(max_int(TIMEOUT_TICKS, LOCK_TICKS) + 1);
    localparam int EW = $clog2(LOCK_ERRS + 1);

    logic      press;
    logic      press_valid;
    key_idx_t  key_idx;

    code_state_t   state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          mm_q, mm_n;
    logic [TW-1:0] tmr_q, tmr_n;
    logic [EW-1:0] errc_q, errc_n;
    logic          ok_q, ok_n;
    logic          erp_q, erp_n;

    logic [CW-1:0] base_cnt;
    logic [CW-1:0] cnt_inc;
    logic          base_mm;
    logic          digit_wrong;
    logic          seq_mm;
    logic [TW-1:0] tmr_inc;
    logic [EW-1:0] err_inc;
    logic          fail;

    key_press_detector u_det (
        .clk         (clk),
        .reset       (reset),
        .keypad      (keypad),
        .press       (press),
        .press_valid (press_valid),
        .key_idx     (key_idx)
    );

    // Expected key index for a given position in the code.
    function automatic key_idx_t code_digit(input logic [CW-1:0] idx);
        key_idx_t d;
        d = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == CW'(i)) begin
                d = CODE[2*i +: 2];
            end
        end
        return d;
    endfunction

    // In IDLE a press always starts a fresh entry, so position and mismatch
    // are taken as zero there regardless of what the registers still hold.
    assign base_cnt    = (state_q == ENTRY) ? cnt_q : '0;
    assign base_mm     = (state_q == ENTRY) ? mm_q  : 1'b0;
    assign cnt_inc     = base_cnt + CW'(1);
    assign digit_wrong = !press_valid || (key_idx != code_digit(base_cnt));
    assign seq_mm      = base_mm | digit_wrong;
    assign tmr_inc     = tmr_q + TW'(1);
    assign err_inc     = errc_q + EW'(1);

    // Next-state logic: presses beat ticks; any failure feeds the shared
    // error accounting at the bottom, which may divert the FSM into lockout.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        mm_n    = mm_q;
        tmr_n   = tmr_q;
        errc_n  = errc_q;
        ok_n    = 1'b0;
        erp_n   = 1'b0;
        fail    = 1'b0;

        case (state_q)
            IDLE, ENTRY: begin
                if (press) begin
                    tmr_n = '0;
                    if (cnt_inc == CW'(CODE_LEN)) begin
                        // Full length consumed: verdict now, back to IDLE.
                        state_n = IDLE;
                        cnt_n   = '0;
                        mm_n    = 1'b0;
                        if (!seq_mm) begin
                            ok_n   = 1'b1;
                            errc_n = '0;
                        end else begin
                            fail = 1'b1;
                        end
                    end else begin
                        state_n = ENTRY;
                        cnt_n   = cnt_inc;
                        mm_n    = seq_mm;
                    end
                end else if ((state_q == ENTRY) && ENA) begin
                    if (tmr_inc == TW'(TIMEOUT_TICKS)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        mm_n    = 1'b0;
                        tmr_n   = '0;
                        fail    = 1'b1;
                    end else begin
                        tmr_n = tmr_inc;
                    end
                end
            end
            LOCKED: begin
                if (ENA) begin
                    if (tmr_inc == TW'(LOCK_TICKS)) begin
                        state_n = IDLE;
                        tmr_n   = '0;
                    end else begin
                        tmr_n = tmr_inc;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                mm_n    = 1'b0;
                tmr_n   = '0;
            end
        endcase

        if (fail) begin
            erp_n = 1'b1;
            if (err_inc == EW'(LOCK_ERRS)) begin
                state_n = LOCKED;
                errc_n  = '0;
                tmr_n   = '0;
            end else begin
                errc_n = err_inc;
            end
        end
    end

    // State and pulse registers; reset aborts any entry or lockout silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mm_q    <= 1'b0;
            tmr_q   <= '0;
            errc_q  <= '0;
            ok_q    <= 1'b0;
            erp_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            mm_q    <= mm_n;
            tmr_q   <= tmr_n;
            errc_q  <= errc_n;
            ok_q    <= ok_n;
            erp_q   <= erp_n;
        end
    end

    assign code_ok      = ok_q;
    assign code_err     = erp_q;
    assign entry_active = (state_q == ENTRY);
    assign locked       = (state_q == LOCKED);
    assign digit_cnt    = cnt_q;

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
- Upstream stage of the siren alarm controller. Converts the synchronized 4-key keypad levels into arm/disarm code events.
- Detects key presses and matches a fixed-length key sequence against a parameterized code.
- Emits one-cycle code_ok / code_err pulses to the siren FSM.
- Enforces an entry timeout and a lockout after repeated failures, both timed by the shared ENA tick from the clock divider (10 Hz at 25 MHz with divider 2500000).

Parameters:
- CODE_LEN, 4: number of digits in the code.
- CODE, 8'b01_11_00_10: expected key indices, 2 bits per digit; digit i at bits [2i+1:2i]. Default sequence is 2,0,3,1.
- TIMEOUT_TICKS, 50: ENA ticks allowed between presses during entry (5 s).
- LOCK_ERRS, 3: consecutive failed codes that trigger lockout.
- LOCK_TICKS, 100: lockout duration in ENA ticks (10 s).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- ENA  input  1  one-cycle divider tick.
- keypad  input  4  synchronized key levels; keypad[i]=1 means key i is held.
- code_ok  output  1  one-cycle pulse: correct code entered.
- code_err  output  1  one-cycle pulse: wrong code or timeout.
- entry_active  output  1  high while a code is partially entered.
- locked  output  1  high during lockout.
- digit_cnt  output  $clog2(CODE_LEN+1)  digits accepted in the current entry.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset=0 at a clk edge):
  - state=IDLE; code_ok, code_err, entry_active, locked = 0; digit_cnt=0.
  - Error and tick counters = 0; mismatch flag = 0.
  - key_held=1, so a key held through reset release is not a press; all keys must first read 0000.
  - Reset mid-entry or mid-lockout aborts with no pulse.
- Press detection:
  - key_held is registered as (keypad != 0).
  - A press event occurs when key_held==0 and keypad!=0.
  - Press is valid if keypad is one-hot; key index = position of the set bit.
  - A non-one-hot press counts as a wrong digit.
- Latency: a press sampled at edge k updates state and digit_cnt at edge k. code_ok and code_err are registered, high for exactly the cycle after edge k.
- FSM states:
  - IDLE: a press sets digit_cnt=1, mismatch=(key!=CODE[0]), clears the timer, goes to ENTRY. entry_active=1.
  - ENTRY, on a press:
    - mismatch |= (key != CODE[digit_cnt]); digit_cnt++; timer cleared.
    - On the CODE_LEN-th press, go to IDLE, digit_cnt=0, entry_active=0.
    - If !mismatch: code_ok pulse, err_cnt=0.
    - Else: code_err pulse, err_cnt++.
    - A wrong early digit gives no early error; the full length is always consumed.
  - ENTRY, timeout: each ENA tick increments the timer. When the timer reaches TIMEOUT_TICKS: code_err pulse, err_cnt++, go to IDLE, digit_cnt=0.
  - Transition to LOCKED: whenever err_cnt would reach LOCK_ERRS, go to LOCKED instead of IDLE. locked=1 from the same edge as the code_err pulse; err_cnt cleared; tick counter cleared.
  - LOCKED: presses are ignored, but key_held is still tracked. After LOCK_TICKS ENA ticks, go to IDLE with locked=0. A key held at unlock does not register until it is released.
- Simultaneous events:
  - Press and timeout-reaching ENA on the same edge: the press wins and the timer is cleared.
  - ENA on the same edge as the final press: the tick is ignored.
- Width rules:
  - Timer width $clog2(max(TIMEOUT_TICKS, LOCK_TICKS)+1); one shared counter is permitted.
  - err_cnt saturates at LOCK_ERRS.
  - digit_cnt never exceeds CODE_LEN.
- code_ok and code_err are never high together and never high in consecutive cycles.

Decomposition:
- Package siren_pkg holds:
  - typedef enum logic [1:0] {IDLE, ENTRY, LOCKED} code_state_t.
  - typedef logic [1:0] key_idx_t.
  - Default constants for CODE_LEN, CODE, TIMEOUT_TICKS, LOCK_TICKS, LOCK_ERRS.
- Sub-module key_press_detector holds key_held, press-event generation, one-hot check and index encoding. Outputs: press, press_valid, key_idx.

Test Plan:
- Hold keypad=0001 through reset release, then keep it held for 10 cycles -> no press, digit_cnt=0, entry_active=0. Release, then press 0100 -> digit_cnt=1, entry_active=1.
- Press/release 0100, 0001, 1000, 0010 -> code_ok=1 for one cycle after the 4th press edge; code_err=0 throughout; digit_cnt=0 and entry_active=0 afterwards.
- Press 0100, 0010, 1000, 0010 -> no pulse after digits 2-3; code_err one cycle after the 4th press; err_cnt=1.
- Press 0100, 0001, then 50 ENA ticks with no key -> code_err on the cycle after the 50th tick; IDLE, digit_cnt=0. With a press coinciding with the 50th tick -> no error, digit_cnt=3.
- Three wrong codes (including one containing 0011) -> locked=1 with the 3rd code_err. A correct code during lockout is ignored. After 100 ticks locked=0; the correct code then yields code_ok.
- Drive reset=0 for one edge after 2 digits -> digit_cnt=0, no pulse. A following full correct code -> code_ok.
